// File: rtl/direction_queue.sv
// direction_queue: holds edge-filtered direction requests in a small FIFO and
// applies the head request to the player heading on game steps. A step applies
// the head only when the maze allows it. A head that keeps failing is dropped
// after TIMEOUT failed steps.
module direction_queue #(
    parameter int DEPTH   = 2,   // queue entries, 1..4
    parameter int TIMEOUT = 8    // failed steps a head survives, 1..255
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    input  logic       step,
    input  logic       turn_ok,
    output logic [1:0] dir,
    output logic       moving,
    output logic [1:0] pending,
    output logic       pending_valid,
    output logic [2:0] count,
    output logic       dropped,
    output logic       expired
);

    localparam logic [2:0] DEPTH_C  = 3'(DEPTH);
    localparam logic [1:0] PTR_LAST = 2'(DEPTH - 1);
    localparam logic [7:0] AGE_LAST = 8'(TIMEOUT - 1);

    // Pointers wrap at DEPTH rather than at a power of two.
    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == PTR_LAST) ? 2'd0 : p + 2'd1;
    endfunction

    // Storage is sized for the largest legal DEPTH. Only the first DEPTH
    // entries are ever addressed.
    logic [1:0] mem_q [0:3];
    logic [1:0] rd_q, rd_d;
    logic [1:0] wr_q, wr_d;
    logic [2:0] count_q, count_d;
    logic [7:0] age_q, age_d;
    logic [1:0] dir_q, dir_d;
    logic       moving_q, moving_d;
    logic [1:0] pending_q, pending_d;
    logic       pv_q, pv_d;
    logic       dropped_q, dropped_d;
    logic       expired_q, expired_d;

    logic       req_vld;
    logic [1:0] req_dir;
    logic [1:0] tail_ptr;
    logic [1:0] head_d;
    logic       nonempty, full, dup, eval, take, tmo, pop, push;

    // Request encode, duplicate check, push/pop arbitration and next state
    always_comb begin
        req_vld = up | down | left | right;
        if (up)        req_dir = 2'b00;
        else if (down) req_dir = 2'b01;
        else if (left) req_dir = 2'b10;
        else           req_dir = 2'b11;

        tail_ptr = (wr_q == 2'd0) ? PTR_LAST : wr_q - 2'd1;
        nonempty = (count_q != 3'd0);
        full     = (count_q == DEPTH_C);

        // The duplicate check always uses the pre-pop tail. When the queue is
        // empty, it compares against the heading the player already has.
        if (nonempty) dup = (req_dir == mem_q[tail_ptr]);
        else          dup = moving_q && (req_dir == dir_q);

        // The step looks only at the head as it was before this edge.
        eval = step && nonempty;
        take = eval && turn_ok;
        tmo  = eval && !turn_ok && (age_q == AGE_LAST);
        pop  = take || tmo;

        // A pop in the same cycle frees the slot that a full queue needs.
        push      = req_vld && !dup && (!full || pop);
        dropped_d = req_vld && !dup && full && !pop;
        expired_d = tmo;

        rd_d = pop  ? ptr_inc(rd_q) : rd_q;
        wr_d = push ? ptr_inc(wr_q) : wr_q;

        count_d = count_q;
        if (push && !pop)      count_d = count_q + 3'd1;
        else if (pop && !push) count_d = count_q - 3'd1;

        age_d = age_q;
        if (pop)       age_d = 8'd0;
        else if (eval) age_d = age_q + 8'd1;

        dir_d    = take ? mem_q[rd_q] : dir_q;
        moving_d = moving_q | take;

        // Next head: a push lands at the head slot when the queue was empty.
        // With DEPTH=1 it also lands there when a full queue pops.
        head_d    = (push && (wr_q == rd_d)) ? req_dir : mem_q[rd_d];
        pv_d      = (count_d != 3'd0);
        pending_d = pv_d ? head_d : 2'b00;
    end

    // State and registered outputs; reset clears everything asynchronously
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) mem_q[i] <= 2'b00;
            rd_q      <= 2'd0;
            wr_q      <= 2'd0;
            count_q   <= 3'd0;
            age_q     <= 8'd0;
            dir_q     <= 2'b00;
            moving_q  <= 1'b0;
            pending_q <= 2'b00;
            pv_q      <= 1'b0;
            dropped_q <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            if (push) mem_q[wr_q] <= req_dir;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            count_q   <= count_d;
            age_q     <= age_d;
            dir_q     <= dir_d;
            moving_q  <= moving_d;
            pending_q <= pending_d;
            pv_q      <= pv_d;
            dropped_q <= dropped_d;
            expired_q <= expired_d;
        end
    end

    assign dir           = dir_q;
    assign moving        = moving_q;
    assign pending       = pending_q;
    assign pending_valid = pv_q;
    assign count         = count_q;
    assign dropped       = dropped_q;
    assign expired       = expired_q;

endmodule

// File: tb/tb_direction_queue.sv
// Directed-vector bench for direction_queue with DEPTH=2 and TIMEOUT=3.
module tb_direction_queue;

    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b1;
    logic       up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
    logic       step = 1'b0, turn_ok = 1'b0;
    logic [1:0] dir, pending;
    logic       moving, pending_valid, dropped, expired;
    logic [2:0] count;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] D_UP = 2'b00, D_DN = 2'b01, D_LF = 2'b10, D_RT = 2'b11;

    direction_queue #(.DEPTH(2), .TIMEOUT(3)) dut (
        .CLOCK_50      (CLOCK_50),
        .reset         (reset),
        .up            (up),
        .down          (down),
        .left          (left),
        .right         (right),
        .step          (step),
        .turn_ok       (turn_ok),
        .dir           (dir),
        .moving        (moving),
        .pending       (pending),
        .pending_valid (pending_valid),
        .count         (count),
        .dropped       (dropped),
        .expired       (expired)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, pass the edge, then sample 1 ns later
    task automatic cyc(input logic u, input logic d, input logic l, input logic r,
                       input logic s, input logic ok);
        up = u; down = d; left = l; right = r; step = s; turn_ok = ok;
        @(posedge CLOCK_50);
        #1;
        up = 0; down = 0; left = 0; right = 0; step = 0; turn_ok = 0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".dir"},     8'(dir), 8'(D_UP));
        chk({tag, ".moving"},  8'(moving), 8'd0);
        chk({tag, ".pending"}, 8'(pending), 8'd0);
        chk({tag, ".pvalid"},  8'(pending_valid), 8'd0);
        chk({tag, ".count"},   8'(count), 8'd0);
        chk({tag, ".dropped"}, 8'(dropped), 8'd0);
        chk({tag, ".expired"}, 8'(expired), 8'd0);
    endtask

    initial begin
        // Reset
        repeat (2) @(posedge CLOCK_50);
        #1;
        chk_reset_state("rst");
        reset = 1'b0;

        // Right pulse, then step with turn_ok=1
        cyc(0, 0, 0, 1, 0, 0);
        chk("rt.pending", 8'(pending), 8'(D_RT));
        chk("rt.count",   8'(count), 8'd1);
        chk("rt.pvalid",  8'(pending_valid), 8'd1);
        cyc(0, 0, 0, 0, 1, 1);
        chk("rt.dir",     8'(dir), 8'(D_RT));
        chk("rt.moving",  8'(moving), 8'd1);
        chk("rt.count0",  8'(count), 8'd0);
        chk("rt.pvalid0", 8'(pending_valid), 8'd0);

        // A step on an empty queue leaves the heading alone
        cyc(0, 0, 0, 0, 1, 1);
        chk("empty.dir",   8'(dir), 8'(D_RT));
        chk("empty.count", 8'(count), 8'd0);

        // Full queue: up, left, then down is dropped
        cyc(1, 0, 0, 0, 0, 0);
        chk("full.c1", 8'(count), 8'd1);
        cyc(0, 0, 1, 0, 0, 0);
        chk("full.c2",   8'(count), 8'd2);
        chk("full.head", 8'(pending), 8'(D_UP));
        cyc(0, 1, 0, 0, 0, 0);
        chk("full.dropped", 8'(dropped), 8'd1);
        chk("full.c2b",     8'(count), 8'd2);
        cyc(0, 0, 0, 0, 0, 0);
        chk("full.dropped_clr", 8'(dropped), 8'd0);
        cyc(0, 0, 0, 0, 1, 1);
        chk("full.dir_up", 8'(dir), 8'(D_UP));
        chk("full.head2",  8'(pending), 8'(D_LF));
        chk("full.c1b",    8'(count), 8'd1);
        cyc(0, 0, 0, 0, 1, 1);
        chk("full.dir_lf", 8'(dir), 8'(D_LF));
        chk("full.c0",     8'(count), 8'd0);

        // Set the heading to down so that a left request is not a duplicate
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 1);
        chk("tmo.dir_dn", 8'(dir), 8'(D_DN));

        // Timeout: left queued, 3 failed steps
        cyc(0, 0, 1, 0, 0, 0);
        chk("tmo.c1", 8'(count), 8'd1);
        cyc(0, 0, 0, 0, 1, 0);
        chk("tmo.exp1", 8'(expired), 8'd0);
        chk("tmo.c1a",  8'(count), 8'd1);
        cyc(0, 0, 0, 0, 1, 0);
        chk("tmo.exp2", 8'(expired), 8'd0);
        cyc(0, 0, 0, 0, 1, 0);
        chk("tmo.exp3", 8'(expired), 8'd1);
        chk("tmo.c0",   8'(count), 8'd0);
        chk("tmo.dir",  8'(dir), 8'(D_DN));
        cyc(0, 0, 0, 0, 0, 0);
        chk("tmo.exp_clr", 8'(expired), 8'd0);

        // Simultaneous up+right queues only up; a repeated left is ignored
        cyc(1, 0, 0, 1, 0, 0);
        chk("sim.count", 8'(count), 8'd1);
        chk("sim.head",  8'(pending), 8'(D_UP));
        cyc(0, 0, 1, 0, 0, 0);
        chk("sim.c2", 8'(count), 8'd2);
        cyc(0, 0, 1, 0, 0, 0);
        chk("dup.count",   8'(count), 8'd2);
        chk("dup.dropped", 8'(dropped), 8'd0);
        cyc(0, 0, 0, 0, 1, 1);
        chk("sim.dir_up", 8'(dir), 8'(D_UP));
        chk("sim.head2",  8'(pending), 8'(D_LF));
        cyc(0, 0, 0, 0, 1, 1);
        chk("sim.dir_lf", 8'(dir), 8'(D_LF));
        chk("sim.c0",     8'(count), 8'd0);

        // Full queue (up, left) with a step and a down pulse together
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        chk("pp.c2pre", 8'(count), 8'd2);
        cyc(0, 1, 0, 0, 1, 1);
        chk("pp.dir",     8'(dir), 8'(D_UP));
        chk("pp.count",   8'(count), 8'd2);
        chk("pp.dropped", 8'(dropped), 8'd0);
        chk("pp.head",    8'(pending), 8'(D_LF));
        // Tail must be down: another down is a silent duplicate, not a drop
        cyc(0, 1, 0, 0, 0, 0);
        chk("pp.tail_dup", 8'(dropped), 8'd0);
        chk("pp.count2",   8'(count), 8'd2);
        chk("pp.moving",   8'(moving), 8'd1);

        // Asynchronous reset between edges with count=2, moving=1
        #2;
        reset = 1'b1;
        #1;
        chk_reset_state("arst");
        #3;
        @(negedge CLOCK_50);
        reset = 1'b0;
        cyc(0, 0, 0, 0, 1, 1);
        chk("arst.count_after", 8'(count), 8'd0);
        chk("arst.dir_after",   8'(dir), 8'(D_UP));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/direction_queue.md
# direction_queue

Buffers one-cycle direction pulses from the four edge-filtered joystick/button inputs and applies them to the player heading at game-step boundaries. It sits between the per-button input filters and the player movement logic. Early turns are held until the maze permits them, or until they expire. Outputs are registered and the block stores no maze state; legality is supplied by the movement logic each step.

## Interface
- DEPTH, 2: queue entries, legal range 1..4
- TIMEOUT, 8: failed steps a head request survives before it is discarded, legal range 1..255
- CLOCK_50  in  1  system clock
- reset  in  1  asynchronous, active-high; clears all state
- up, down, left, right  in  1 each  one-cycle request pulses, already edge-filtered
- step  in  1  one-cycle game-tick pulse from movement logic
- turn_ok  in  1  sampled only when step=1; 1 = direction `pending` is legal at this tile
- dir  out  2  current heading: 00 up, 01 down, 10 left, 11 right
- moving  out  1  1 once any turn has been applied
- pending  out  2  head-of-queue direction; 00 when empty
- pending_valid  out  1  queue non-empty
- count  out  3  occupied entries, 0..DEPTH
- dropped  out  1  one-cycle pulse: request rejected because queue full
- expired  out  1  one-cycle pulse: head discarded after TIMEOUT failed steps

## Operation
- Request encode: if any of up/down/left/right is high, the request is the highest-priority one: up > down > left > right. Other simultaneous pulses are ignored without a dropped pulse.
- Duplicate suppression compares the request against the tail entry when the queue is non-empty. When the queue is empty and moving=1, it compares against dir. A matching request is discarded silently: no push, no dropped pulse.
- Push: the request is written at the tail and count increments. If count==DEPTH and no pop occurs this cycle, the request is rejected and dropped=1 for that cycle.
- Step evaluation happens only when step=1 and pending_valid=1, using the pre-cycle head:
  - turn_ok=1: dir <= head, moving <= 1, pop head, age <= 0.
  - turn_ok=0 and age < TIMEOUT-1: age <= age+1.
  - turn_ok=0 and age == TIMEOUT-1: pop head, age <= 0, expired=1.
- step with an empty queue: no effect. dir and moving hold.
- Pop and push in the same cycle: both occur and count is unchanged. A full queue accepts the push when a pop happens that cycle, with no dropped pulse. Duplicate check still uses the pre-pop tail.
- A request pushed in a step cycle is not evaluated in that step; earliest application is the next step.
- age is internal, 8-bit, and tracks the head only. It resets to 0 on every pop.
- Queue pointers wrap modulo DEPTH.

## Timing
- Reset values: dir=00, moving=0, pending=00, pending_valid=0, count=0, dropped=0, expired=0, age=0. Queue contents are cleared.
- reset asserted mid-operation clears state immediately and asynchronously. It overrides any push or step in the same cycle.
- Push latency 1: a request pulse at edge N appears in pending, pending_valid and count after edge N.
- Turn latency 1: dir, moving and the pop take effect after the step edge.
- dropped and expired are high for exactly the one cycle following the causing edge.
- No combinational path from any input to any output.

## Test plan
- Reset, then a right pulse, then step with turn_ok=1.
  - After the pulse: pending=11, count=1.
  - After the step: dir=11, moving=1, count=0.
- DEPTH=2 full case: pulse up, then left, then down on separate cycles.
  - Third pulse produces dropped=1 for one cycle; count stays 2 and queue holds up, left.
- TIMEOUT=3: queue holds left; issue 3 steps with turn_ok=0.
  - expired=1 after the third step; count=0; dir unchanged.
- Simultaneous inputs.
  - up and right pulsed in the same cycle: only up is queued.
  - With tail=left, a left pulse is ignored: count unchanged, no dropped.
- Full queue (up, left) with a step (turn_ok=1) and a down pulse in the same cycle.
  - Result: dir=00, queue holds left, down; count=2; dropped=0.
- Reset asserted between clock edges while count=2 and moving=1.
  - All outputs return to reset values before the next edge.
